// File: rtl/nr_div_sgn.sv
// Non-restoring iterative divider with signed/unsigned mode, retiring one quotient bit per clock.
// Divide-by-zero and signed overflow bypass the iteration and finish in a single step.
module nr_div_sgn #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         signed_mode,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero,
   output logic         overflow
);

   localparam int CW = $clog2(N + 1);
   localparam logic [N-1:0]  ZERO_N  = {N{1'b0}};
   localparam logic [N-1:0]  ONES_N  = {N{1'b1}};
   localparam logic [N-1:0]  ONE_N   = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]  MIN_N   = {1'b1, {(N-1){1'b0}}};
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_N   = CW'(N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic [N:0]    a, a_nx;
   logic [N-1:0]  q, q_nx;
   logic [N-1:0]  d, d_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          neg_q, neg_q_nx;
   logic          neg_r, neg_r_nx;
   logic          dz_p, dz_nx;
   logic          ov_p, ov_nx;
   logic          busy_nx, done_nx, dzo_nx, ovo_nx;
   logic [N-1:0]  quo_nx, rem_nx;

   logic          dvd_neg, dvs_neg, ovf_case;
   logic [N-1:0]  dvd_mag, dvs_mag;
   logic [N:0]    a_sh, a_it, a_fix;

   // Operand magnitudes, signs and the single signed overflow pattern
   always_comb begin
      dvd_neg  = signed_mode & dividend[N-1];
      dvs_neg  = signed_mode & divisor[N-1];
      dvd_mag  = dvd_neg ? (~dividend + ONE_N) : dividend;
      dvs_mag  = dvs_neg ? (~divisor + ONE_N) : divisor;
      ovf_case = signed_mode & (dividend == MIN_N) & (divisor == ONES_N);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state, datapath step and output updates
   always_comb begin
      state_nx = state;
      a_nx     = a;
      q_nx     = q;
      d_nx     = d;
      cnt_nx   = cnt;
      neg_q_nx = neg_q;
      neg_r_nx = neg_r;
      dz_nx    = dz_p;
      ov_nx    = ov_p;
      busy_nx  = busy;
      done_nx  = 1'b0;
      quo_nx   = quotient;
      rem_nx   = remainder;
      dzo_nx   = div_by_zero;
      ovo_nx   = overflow;

      // A is kept N+1 bits so its sign bit steers add-versus-subtract
      a_sh  = {a[N-1:0], q[N-1]};
      a_it  = a[N] ? (a_sh + {1'b0, d}) : (a_sh - {1'b0, d});
      a_fix = a[N] ? (a + {1'b0, d}) : a;

      case (state)
         IDLE: begin
            if (start) begin
               busy_nx  = 1'b1;
               dzo_nx   = 1'b0;
               ovo_nx   = 1'b0;
               dz_nx    = 1'b0;
               ov_nx    = 1'b0;
               d_nx     = dvs_mag;
               neg_q_nx = dvd_neg ^ dvs_neg;
               neg_r_nx = dvd_neg;
               cnt_nx   = CNT_N;
               if (divisor == ZERO_N) begin
                  dz_nx    = 1'b1;
                  q_nx     = ONES_N;
                  a_nx     = {1'b0, dividend};
                  state_nx = DONE;
               end else if (ovf_case) begin
                  ov_nx    = 1'b1;
                  q_nx     = MIN_N;
                  a_nx     = {(N+1){1'b0}};
                  state_nx = DONE;
               end else begin
                  q_nx     = dvd_mag;
                  a_nx     = {(N+1){1'b0}};
                  state_nx = ITER;
               end
            end else begin
               state_nx = IDLE;
            end
         end
         ITER: begin
            a_nx   = a_it;
            q_nx   = {q[N-2:0], ~a_it[N]};
            cnt_nx = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
               state_nx = FIX;
            end else begin
               state_nx = ITER;
            end
         end
         FIX: begin
            q_nx     = neg_q ? (~q + ONE_N) : q;
            a_nx     = {1'b0, (neg_r ? (~a_fix[N-1:0] + ONE_N) : a_fix[N-1:0])};
            state_nx = DONE;
         end
         DONE: begin
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            quo_nx   = q;
            rem_nx   = a[N-1:0];
            dzo_nx   = dz_p;
            ovo_nx   = ov_p;
            state_nx = IDLE;
         end
         default: begin
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a           <= {(N+1){1'b0}};
         q           <= ZERO_N;
         d           <= ZERO_N;
         cnt         <= {CW{1'b0}};
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         dz_p        <= 1'b0;
         ov_p        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= ZERO_N;
         remainder   <= ZERO_N;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         a           <= a_nx;
         q           <= q_nx;
         d           <= d_nx;
         cnt         <= cnt_nx;
         neg_q       <= neg_q_nx;
         neg_r       <= neg_r_nx;
         dz_p        <= dz_nx;
         ov_p        <= ov_nx;
         busy        <= busy_nx;
         done        <= done_nx;
         quotient    <= quo_nx;
         remainder   <= rem_nx;
         div_by_zero <= dzo_nx;
         overflow    <= ovo_nx;
      end
   end

endmodule
